// File: rtl/ifetch8.sv
// Instruction-fetch stage for the 8-bit-address instruction RAM: PC, IR register, decode handshake, branch redirect, halt on zero word.
// Optional build macro IFETCH8_PERF_EN adds saturating fetch/stall performance counters (PERF_FETCH, PERF_STALL).
module ifetch8 #(
  parameter int AW       = 8,
  parameter int IW       = 16,
  parameter int OFFW     = 6,
  parameter int BOOT_CYC = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic [AW-1:0]   IRAM_ADDR,
  input  logic [IW-1:0]   IRAM_Q,
  output logic [IW-1:0]   IR,
  output logic [AW-1:0]   IR_PC,
  output logic            IR_VALID,
  input  logic            DEC_READY,
  input  logic            BR_TAKEN,
  input  logic [AW-1:0]   BR_PC,
  input  logic [OFFW-1:0] BR_OFF,
  input  logic            RESTART,
  output logic            HALTED
`ifdef IFETCH8_PERF_EN
  ,
  output logic [15:0]     PERF_FETCH,
  output logic [15:0]     PERF_STALL
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int CW = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYC - 1);

  state_t        state;
  logic [CW-1:0] boot_cnt;
  logic [AW-1:0] pc;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] br_sum;
  logic [AW-1:0] br_target;
  logic          slot_free;
  logic          zero_word;

  assign IRAM_ADDR = pc;

  // Word offset is sign-extended and doubled into a byte offset; bit 0 is forced low so PC stays word aligned.
  assign off_ext   = {{(AW-OFFW){BR_OFF[OFFW-1]}}, BR_OFF};
  assign br_sum    = BR_PC + (off_ext << 1);
  assign br_target = {br_sum[AW-1:1], 1'b0};

  assign slot_free = !IR_VALID || DEC_READY;
  assign zero_word = (IRAM_Q == '0);

  // NOTE: all state uses non-blocking assignments inside one clocked block so every
  // register samples the pre-edge values; reset is synchronous, so it is tested inside the edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      pc       <= '0;
      IR       <= '0;
      IR_PC    <= '0;
      IR_VALID <= 1'b0;
      HALTED   <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) state <= ST_RUN;
          else                       boot_cnt <= boot_cnt + CW'(1);
        end
        ST_RUN: begin
          if (BR_TAKEN) begin
            pc       <= br_target;
            IR_VALID <= 1'b0;
          end else if (slot_free && zero_word) begin
            IR_VALID <= 1'b0;
            state    <= ST_HALT;
            HALTED   <= 1'b1;
          end else if (slot_free) begin
            IR       <= IRAM_Q;
            IR_PC    <= pc;
            IR_VALID <= 1'b1;
            pc       <= pc + AW'(2);
          end
        end
        ST_HALT: begin
          // A pending branch resolution outranks a restart request.
          if (BR_TAKEN) begin
            pc     <= br_target;
            state  <= ST_RUN;
            HALTED <= 1'b0;
          end else if (RESTART) begin
            pc     <= '0;
            state  <= ST_RUN;
            HALTED <= 1'b0;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifdef IFETCH8_PERF_EN
  logic fetch_ev;
  logic stall_ev;

  // Redirect cycles count as stalls: they are the one-cycle bubble before the target arrives.
  assign fetch_ev = (state == ST_RUN) && !BR_TAKEN && slot_free && !zero_word;
  assign stall_ev = (state == ST_RUN) && (BR_TAKEN || !slot_free);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PERF_FETCH <= '0;
      PERF_STALL <= '0;
    end else begin
      if (fetch_ev && (PERF_FETCH != 16'hFFFF)) PERF_FETCH <= PERF_FETCH + 16'd1;
      if (stall_ev && (PERF_STALL != 16'hFFFF)) PERF_STALL <= PERF_STALL + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch8.sv
// Directed bench for ifetch8: fetch/halt, stall, branch redirects, PC wrap, halt exit and reset during a stall.
module tb_ifetch8;

  logic        CLK;
  logic        RESET;
  logic [7:0]  IRAM_ADDR;
  logic [15:0] IRAM_Q;
  logic [15:0] IR;
  logic [7:0]  IR_PC;
  logic        IR_VALID;
  logic        DEC_READY;
  logic        BR_TAKEN;
  logic [7:0]  BR_PC;
  logic [5:0]  BR_OFF;
  logic        RESTART;
  logic        HALTED;
`ifdef IFETCH8_PERF_EN
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
`endif

  logic [15:0] mem [128];
  int          total;
  int          bad;
  logic [33:0] exp;
  wire  [33:0] obs = {IR_VALID, HALTED, IRAM_ADDR, IR_PC, IR};

  assign IRAM_Q = mem[IRAM_ADDR[7:1]];

  ifetch8 dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IRAM_ADDR (IRAM_ADDR),
    .IRAM_Q    (IRAM_Q),
    .IR        (IR),
    .IR_PC     (IR_PC),
    .IR_VALID  (IR_VALID),
    .DEC_READY (DEC_READY),
    .BR_TAKEN  (BR_TAKEN),
    .BR_PC     (BR_PC),
    .BR_OFF    (BR_OFF),
    .RESTART   (RESTART),
    .HALTED    (HALTED)
`ifdef IFETCH8_PERF_EN
    ,
    .PERF_FETCH(perf_fetch),
    .PERF_STALL(perf_stall)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Observation word: {valid, halted, addr, ir_pc, ir}
  task automatic test_reset();
    RESET = 1'b0; DEC_READY = 1'b1; BR_TAKEN = 1'b0; BR_PC = 8'h00; BR_OFF = 6'h00; RESTART = 1'b0;
    @(negedge CLK); @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h00, 8'h00, 16'h0000};
    if (obs !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
    // Branch during BOOT must be ignored.
    RESET = 1'b1; BR_TAKEN = 1'b1; BR_PC = 8'h40;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h00, 8'h00, 16'h0000};
    if (obs !== exp) begin bad++; $display("FAIL boot_hold got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0;
  endtask

  task automatic test_fetch_halt();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      total++; exp = {1'b1, 1'b0, 8'(2*i+2), 8'(2*i), 16'(16'h1000 + i)};
      if (obs !== exp) begin bad++; $display("FAIL fetch_%0d got=%h exp=%h", i, obs, exp); end
    end
    @(negedge CLK);
    total++; exp = {1'b0, 1'b1, 8'h08, 8'h06, 16'h1003};
    if (obs !== exp) begin bad++; $display("FAIL halt_on_zero got=%h exp=%h", obs, exp); end
    @(negedge CLK);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL halt_hold got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_restart();
    RESTART = 1'b1;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h00, 8'h06, 16'h1003};
    if (obs !== exp) begin bad++; $display("FAIL restart got=%h exp=%h", obs, exp); end
    RESTART = 1'b0;
  endtask

  task automatic test_stall();
    DEC_READY = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h02, 8'h00, 16'h1000};
    if (obs !== exp) begin bad++; $display("FAIL stall_capture got=%h exp=%h", obs, exp); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, obs, exp); end
    end
    DEC_READY = 1'b1;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h04, 8'h02, 16'h1001};
    if (obs !== exp) begin bad++; $display("FAIL stall_release got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_branch();
    BR_TAKEN = 1'b1; BR_PC = 8'h22; BR_OFF = 6'b111000;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h12, 8'h02, 16'h1001};
    if (obs !== exp) begin bad++; $display("FAIL br_back_redirect got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h14, 8'h12, 16'h1009};
    if (obs !== exp) begin bad++; $display("FAIL br_back_target got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b1; BR_PC = 8'h3A; BR_OFF = 6'b010111;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h68, 8'h12, 16'h1009};
    if (obs !== exp) begin bad++; $display("FAIL br_fwd_redirect got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h6A, 8'h68, 16'h1034};
    if (obs !== exp) begin bad++; $display("FAIL br_fwd_target got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_wrap();
    BR_TAKEN = 1'b1; BR_PC = 8'hF0; BR_OFF = 6'b011111;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h2E, 8'h68, 16'h1034};
    if (obs !== exp) begin bad++; $display("FAIL br_sum_wrap got=%h exp=%h", obs, exp); end
    BR_PC = 8'hFE; BR_OFF = 6'b000000;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'hFE, 8'h68, 16'h1034};
    if (obs !== exp) begin bad++; $display("FAIL br_back_to_back got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h00, 8'hFE, 16'h107F};
    if (obs !== exp) begin bad++; $display("FAIL pc_wrap got=%h exp=%h", obs, exp); end
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h02, 8'h00, 16'h1000};
    if (obs !== exp) begin bad++; $display("FAIL after_wrap got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_branch_vs_zero();
    BR_TAKEN = 1'b1; BR_PC = 8'h08; BR_OFF = 6'b000000;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h08, 8'h00, 16'h1000};
    if (obs !== exp) begin bad++; $display("FAIL br_to_zero got=%h exp=%h", obs, exp); end
    BR_PC = 8'h10;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h10, 8'h00, 16'h1000};
    if (obs !== exp) begin bad++; $display("FAIL br_over_zero got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h12, 8'h10, 16'h1008};
    if (obs !== exp) begin bad++; $display("FAIL br_over_zero_target got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_halt_branch();
    BR_TAKEN = 1'b1; BR_PC = 8'h08; BR_OFF = 6'b000000;
    @(negedge CLK);
    BR_TAKEN = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b1, 8'h08, 8'h10, 16'h1008};
    if (obs !== exp) begin bad++; $display("FAIL halt_again got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b1; BR_PC = 8'h20; RESTART = 1'b1;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h20, 8'h10, 16'h1008};
    if (obs !== exp) begin bad++; $display("FAIL halt_br_wins got=%h exp=%h", obs, exp); end
    BR_TAKEN = 1'b0; RESTART = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h22, 8'h20, 16'h1010};
    if (obs !== exp) begin bad++; $display("FAIL halt_br_target got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_stall();
    DEC_READY = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h22, 8'h20, 16'h1010};
    if (obs !== exp) begin bad++; $display("FAIL pre_reset_stall got=%h exp=%h", obs, exp); end
    RESET = 1'b0;
    @(negedge CLK);
    total++; exp = {1'b0, 1'b0, 8'h00, 8'h00, 16'h0000};
    if (obs !== exp) begin bad++; $display("FAIL reset_mid_stall got=%h exp=%h", obs, exp); end
`ifdef IFETCH8_PERF_EN
    total++;
    if (perf_fetch !== 16'h0000) begin bad++; $display("FAIL perf_fetch_reset got=%h exp=0000", perf_fetch); end
`endif
    RESET = 1'b1; DEC_READY = 1'b1;
    @(negedge CLK);
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reboot_hold got=%h exp=%h", obs, exp); end
    @(negedge CLK);
    total++; exp = {1'b1, 1'b0, 8'h02, 8'h00, 16'h1000};
    if (obs !== exp) begin bad++; $display("FAIL reboot_fetch got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 128; i++) mem[i] = 16'(16'h1000 + i);
    mem[4] = 16'h0000;
    test_reset();
    test_fetch_halt();
    test_restart();
    test_stall();
    test_branch();
    test_wrap();
    test_branch_vs_zero();
    test_halt_branch();
    test_reset_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
